// File: rtl/pair_issue_tx_pkg.sv
// Shared types and constants for the single-to-dual issue pairing buffer.
package pair_issue_tx_pkg;

  localparam int Depth = 2;

  // Legal dual-issue valid encodings: none, oldest only, both.
  localparam logic [1:0] V0 = 2'b00;
  localparam logic [1:0] V1 = 2'b01;
  localparam logic [1:0] V2 = 2'b11;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    WAIT  = 2'd1,
    ONE   = 2'd2,
    TWO   = 2'd3
  } state_e;

  function automatic logic [1:0] level_of(input state_e s);
    unique case (s)
      EMPTY:   level_of = 2'd0;
      TWO:     level_of = 2'd2;
      default: level_of = 2'd1;
    endcase
  endfunction

endpackage

// File: rtl/pair_issue_tx.sv
// Pairs a single-issue upstream stream into dual-issue bundles; a lone entry
// waits up to MaxWait cycles for a partner before it is offered single.
module pair_issue_tx
  import pair_issue_tx_pkg::*;
#(
  parameter int Width   = 32,
  parameter int MaxWait = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             in_valid_i,
  input  logic [Width-1:0] in_data_i,
  output logic             in_rdy_o,
  output logic [1:0]       out_valid_o,
  output logic [Width-1:0] out_data0_o,
  output logic [Width-1:0] out_data1_o,
  input  logic [1:0]       out_rdy_i,
  output logic [1:0]       level_o
);

  state_e           state_q, state_d;
  logic [3:0]       wait_cnt_q, wait_cnt_d;
  logic [Width-1:0] slot0_q, slot1_q, slot0_d, slot1_d;
  logic [1:0]       level, level_nxt, n_out;
  logic             accept, pop0, pop1;

  assign level    = level_of(state_q);
  assign level_o  = level;
  assign in_rdy_o = (level != 2'(Depth)) && !flush_i;
  assign accept   = in_valid_i & in_rdy_o;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    out_valid_o = V0;
    if (!flush_i) begin
      unique case (state_q)
        ONE:     out_valid_o = V1;
        TWO:     out_valid_o = V2;
        default: out_valid_o = V0;
      endcase
    end
  end

  // A ready of 10 cannot pop slot1 alone because pop1 requires pop0.
  assign pop0      = out_valid_o[0] & out_rdy_i[0];
  assign pop1      = pop0 & out_valid_o[1] & out_rdy_i[1];
  assign n_out     = pop1 ? 2'd2 : {1'b0, pop0};
  assign level_nxt = level + {1'b0, accept} - n_out;

  assign out_data0_o = slot0_q;
  assign out_data1_o = slot1_q;

  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    if (n_out == 2'd1 && level == 2'd2) slot0_d = slot1_q;
    if (accept) begin
      if (level - n_out == 2'd0) slot0_d = in_data_i;
      else                       slot1_d = in_data_i;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = 4'd0;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      case (level_nxt)
        2'd0: state_d = EMPTY;
        2'd2: state_d = TWO;
        default: begin
          if (accept) begin
            // A freshly lone entry always starts a new wait window.
            if (MaxWait > 0) state_d = WAIT;
            else             state_d = ONE;
          end else if (state_q == TWO) begin
            state_d = ONE;
          end else if (state_q == WAIT) begin
            wait_cnt_d = (wait_cnt_q == 4'hf) ? wait_cnt_q : wait_cnt_q + 4'd1;
            if ({1'b0, wait_cnt_q} + 5'd1 >= 5'(MaxWait)) state_d = ONE;
            else                                          state_d = WAIT;
          end else begin
            state_d    = ONE;
            wait_cnt_d = wait_cnt_q;
          end
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= EMPTY;
      wait_cnt_q <= 4'd0;
      // NOTE: the two slots are plain flops and are reset so outputs read 0 out of reset.
      slot0_q    <= '0;
      slot1_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      slot0_q    <= slot0_d;
      slot1_q    <= slot1_d;
    end
  end

endmodule

// File: tb/tb_pair_issue_tx.sv
// Directed vectors plus a scoreboarded random run for pair_issue_tx.
module tb_pair_issue_tx;
  import pair_issue_tx_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush, in_valid;
  logic [W-1:0] in_data;
  logic [1:0]   out_rdy;

  logic         u0_in_rdy, u3_in_rdy;
  logic [1:0]   u0_ov, u3_ov, u0_level, u3_level;
  logic [W-1:0] u0_d0, u0_d1, u3_d0, u3_d1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pair_issue_tx #(.Width(W), .MaxWait(0)) u_mw0 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid),
    .in_data_i(in_data), .in_rdy_o(u0_in_rdy), .out_valid_o(u0_ov),
    .out_data0_o(u0_d0), .out_data1_o(u0_d1), .out_rdy_i(out_rdy), .level_o(u0_level)
  );

  pair_issue_tx #(.Width(W), .MaxWait(3)) u_mw3 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid),
    .in_data_i(in_data), .in_rdy_o(u3_in_rdy), .out_valid_o(u3_ov),
    .out_data0_o(u3_d0), .out_data1_o(u3_d1), .out_rdy_i(out_rdy), .level_o(u3_level)
  );

  typedef struct {
    logic         flush;
    logic         iv;
    logic [W-1:0] din;
    logic [1:0]   ordy;
    logic         e_rdy;
    logic [1:0]   e_ov;
    logic [W-1:0] e_d0;
    logic [W-1:0] e_d1;
    logic [1:0]   e_lvl;
  } vec_t;

  vec_t vecs[23];
  logic [W-1:0] q[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic f, input logic iv, input logic [W-1:0] d, input logic [1:0] r);
    flush    = f;
    in_valid = iv;
    in_data  = d;
    out_rdy  = r;
  endtask

  initial begin
    // Rows run on the MaxWait=3 instance, one clock cycle per row, from reset.
    vecs[0]  = '{1'b0, 1'b1, 32'hA1, 2'b11, 1'b1, 2'b00, 32'h0,  32'h0,  2'd0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,  2'b11, 1'b1, 2'b00, 32'h0,  32'h0,  2'd1};
    vecs[2]  = '{1'b0, 1'b1, 32'hB2, 2'b11, 1'b1, 2'b00, 32'h0,  32'h0,  2'd1};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,  2'b00, 1'b0, 2'b11, 32'hA1, 32'hB2, 2'd2};
    vecs[4]  = '{1'b0, 1'b1, 32'hC3, 2'b01, 1'b0, 2'b11, 32'hA1, 32'hB2, 2'd2};
    vecs[5]  = '{1'b0, 1'b1, 32'hC3, 2'b00, 1'b1, 2'b01, 32'hB2, 32'h0,  2'd1};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,  2'b10, 1'b0, 2'b11, 32'hB2, 32'hC3, 2'd2};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,  2'b10, 1'b0, 2'b11, 32'hB2, 32'hC3, 2'd2};
    vecs[8]  = '{1'b1, 1'b1, 32'hD4, 2'b11, 1'b0, 2'b00, 32'h0,  32'h0,  2'd2};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,  2'b11, 1'b1, 2'b00, 32'h0,  32'h0,  2'd0};
    vecs[10] = '{1'b0, 1'b1, 32'hD4, 2'b00, 1'b1, 2'b00, 32'h0,  32'h0,  2'd0};
    vecs[11] = '{1'b0, 1'b0, 32'h0,  2'b00, 1'b1, 2'b00, 32'h0,  32'h0,  2'd1};
    vecs[12] = '{1'b0, 1'b0, 32'h0,  2'b00, 1'b1, 2'b00, 32'h0,  32'h0,  2'd1};
    vecs[13] = '{1'b0, 1'b0, 32'h0,  2'b00, 1'b1, 2'b00, 32'h0,  32'h0,  2'd1};
    vecs[14] = '{1'b0, 1'b1, 32'hE5, 2'b01, 1'b1, 2'b01, 32'hD4, 32'h0,  2'd1};
    vecs[15] = '{1'b0, 1'b0, 32'h0,  2'b11, 1'b1, 2'b00, 32'h0,  32'h0,  2'd1};
    vecs[16] = '{1'b0, 1'b0, 32'h0,  2'b11, 1'b1, 2'b00, 32'h0,  32'h0,  2'd1};
    vecs[17] = '{1'b0, 1'b0, 32'h0,  2'b11, 1'b1, 2'b00, 32'h0,  32'h0,  2'd1};
    vecs[18] = '{1'b0, 1'b0, 32'h0,  2'b11, 1'b1, 2'b01, 32'hE5, 32'h0,  2'd1};
    vecs[19] = '{1'b0, 1'b1, 32'hF6, 2'b11, 1'b1, 2'b00, 32'h0,  32'h0,  2'd0};
    vecs[20] = '{1'b0, 1'b1, 32'hA7, 2'b11, 1'b1, 2'b00, 32'h0,  32'h0,  2'd1};
    vecs[21] = '{1'b0, 1'b0, 32'h0,  2'b11, 1'b0, 2'b11, 32'hF6, 32'hA7, 2'd2};
    vecs[22] = '{1'b0, 1'b0, 32'h0,  2'b00, 1'b1, 2'b00, 32'h0,  32'h0,  2'd0};

    rst_n = 1'b0;
    drive(1'b0, 1'b0, '0, 2'b00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.mw0.rdy",   u0_in_rdy, 1);
    check("rst.mw0.ov",    u0_ov,     0);
    check("rst.mw0.level", u0_level,  0);
    check("rst.mw0.d0",    u0_d0,     0);
    check("rst.mw0.d1",    u0_d1,     0);
    check("rst.mw3.rdy",   u3_in_rdy, 1);
    check("rst.mw3.ov",    u3_ov,     0);
    check("rst.mw3.level", u3_level,  0);
    check("rst.mw3.d0",    u3_d0,     0);
    check("rst.mw3.d1",    u3_d1,     0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 23; i++) begin
      drive(vecs[i].flush, vecs[i].iv, vecs[i].din, vecs[i].ordy);
      @(negedge clk);
      check($sformatf("vec%0d.rdy", i),   u3_in_rdy, vecs[i].e_rdy);
      check($sformatf("vec%0d.ov", i),    u3_ov,     vecs[i].e_ov);
      check($sformatf("vec%0d.level", i), u3_level,  vecs[i].e_lvl);
      if (vecs[i].e_ov[0]) check($sformatf("vec%0d.d0", i), u3_d0, vecs[i].e_d0);
      if (vecs[i].e_ov[1]) check($sformatf("vec%0d.d1", i), u3_d1, vecs[i].e_d1);
      tick();
    end

    // MaxWait=0: a lone entry is offered single one cycle after it is taken.
    drive(1'b1, 1'b0, '0, 2'b00);
    tick();
    drive(1'b0, 1'b1, 32'h1234_5678, 2'b11);
    @(negedge clk);
    check("mw0.c0.rdy", u0_in_rdy, 1);
    check("mw0.c0.ov",  u0_ov,     0);
    tick();
    drive(1'b0, 1'b0, '0, 2'b11);
    @(negedge clk);
    check("mw0.c1.ov",    u0_ov,    2'b01);
    check("mw0.c1.d0",    u0_d0,    32'h1234_5678);
    check("mw0.c1.level", u0_level, 1);
    tick();
    @(negedge clk);
    check("mw0.c2.level", u0_level, 0);
    check("mw0.c2.ov",    u0_ov,    0);
    tick();

    // Full and stalled: upstream keeps offering but nothing moves.
    drive(1'b1, 1'b0, '0, 2'b00);
    tick();
    drive(1'b0, 1'b1, 32'h0000_0111, 2'b00);
    tick();
    drive(1'b0, 1'b1, 32'h0000_0222, 2'b00);
    tick();
    drive(1'b0, 1'b1, 32'h0000_0333, 2'b00);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("stall%0d.rdy", k),   u3_in_rdy, 0);
      check($sformatf("stall%0d.ov", k),    u3_ov,     2'b11);
      check($sformatf("stall%0d.d0", k),    u3_d0,     32'h0000_0111);
      check($sformatf("stall%0d.d1", k),    u3_d1,     32'h0000_0222);
      check($sformatf("stall%0d.level", k), u3_level,  2);
      tick();
    end

    drive(1'b1, 1'b0, '0, 2'b00);
    tick();
    q.delete();
    for (int c = 0; c < 400; c++) begin
      logic       exp_rdy, acc;
      logic [1:0] r;
      int         n;
      case ($urandom_range(0, 3))
        0:       r = 2'b00;
        1:       r = 2'b01;
        2:       r = 2'b11;
        default: r = 2'b10;
      endcase
      drive(($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)), $urandom, r);
      @(negedge clk);
      exp_rdy = (q.size() != 2) && !flush;
      check("rnd.rdy",      u3_in_rdy,            exp_rdy);
      check("rnd.ov_legal", (u3_ov != 2'b10),     1);
      check("rnd.level",    u3_level,             q.size());
      if (flush) check("rnd.flush_ov", u3_ov, 0);
      if (u3_ov[0]) begin
        if (q.size() >= 1) check("rnd.d0", u3_d0, q[0]);
        else               check("rnd.ov0_empty", q.size(), 1);
      end
      if (u3_ov[1]) begin
        if (q.size() >= 2) check("rnd.d1", u3_d1, q[1]);
        else               check("rnd.ov1_short", q.size(), 2);
      end
      acc = in_valid && exp_rdy;
      n   = 0;
      if (u3_ov[0] && out_rdy[0]) n = (u3_ov[1] && out_rdy[1]) ? 2 : 1;
      if (flush) begin
        q.delete();
      end else begin
        for (int p = 0; p < n && q.size() > 0; p++) void'(q.pop_front());
        if (acc) q.push_back(in_data);
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
